// File: rtl/wshb_fb_responder.sv
// Wishbone B4 slave fronting the on-chip framebuffer RAM.
// Answers classic cycles and linear incrementing bursts. A programmable
// number of wait states is inserted before the first ack/err of each
// cycle or burst. Out-of-range word addresses answer with err.
module wshb_fb_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0,
  parameter bit BURST_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_ms,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err
);

  localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);
  localparam logic [3:0]  WS_M1       = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_BEAT = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic [29:0] ptr;

  logic [31:0] mem [0:MEM_WORDS-1];
  logic [31:0] rd_p1;
  logic [31:0] rd_next;
  logic [29:0] rd_word;

  logic req;
  logic oor;
  logic ack_q;
  logic err_q;
  logic cont;
  logic accept;
  logic wr_en;

  // Byte-lane bits of the address carry no meaning for a word-wide RAM.
  logic unused_adr_bits;
  assign unused_adr_bits = ^adr[1:0];

  assign req    = cyc & stb;
  assign oor    = ({2'b00, ptr} >= MEM_WORDS_L);
  assign ack_q  = (state == ST_BEAT) & ~oor;
  assign err_q  = (state == ST_BEAT) & oor;
  assign ack    = ack_q & req;
  assign err    = err_q & req;
  assign dat_sm = ack_q ? rd_p1 : 32'd0;

  // A new request can be taken from IDLE or straight out of the GAP cycle,
  // which is what gives back-to-back classic cycles their 2+WS cadence.
  assign accept = ((state == ST_IDLE) | (state == ST_GAP)) & req;
  assign cont   = (state == ST_BEAT) & req & ~oor & BURST_EN
                & (cti == 3'b010) & (bte == 2'b00);
  // Only a beat whose ack is actually visible commits write data.
  assign wr_en  = ack_q & req & we;

  // Word to fetch for the next visible beat: new address, prefetch, or hold.
  always_comb begin
    rd_word = ptr;
    if (accept) begin
      rd_word = adr[31:2];
    end else if (cont) begin
      rd_word = ptr + 30'd1;
    end
  end

  // RAM read port with write-data bypass when the same word is being written.
  always_comb begin
    rd_next = mem[rd_word[AW-1:0]];
    if (wr_en && (rd_word == ptr)) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) rd_next[8*i +: 8] = dat_ms[8*i +: 8];
      end
    end
  end

  // Registered read data; one cycle of RAM latency.
  always_ff @(posedge clk) begin
    rd_p1 <= rd_next;
  end

  // Byte-enabled RAM write at the current pointer during an acked write beat.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) mem[ptr[AW-1:0]][8*i +: 8] <= dat_ms[8*i +: 8];
      end
    end
  end

  // Bus FSM: accept, optional wait states, beats, then one idle gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      ptr      <= 30'd0;
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          if (req) begin
            ptr <= adr[31:2];
            if (WAIT_STATES == 0) begin
              state <= ST_BEAT;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WS_M1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state <= ST_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= ST_BEAT;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_BEAT: begin
          if (cont) begin
            ptr <= ptr + 30'd1;
          end else begin
            state <= ST_GAP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wshb_fb_responder.md
Name: wshb_fb_responder

Overview:
- Wishbone B4 slave holding the framebuffer in on-chip RAM; it answers the display reader's fetches and the producer's writes.
- Supports classic cycles and linear incremental bursts (cti=010, bte=00), with a programmable number of wait states.
- Serves as the bus-side counterpart of the display fetch master, both in simulation and on the SoC.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; word address = adr[31:2].
- WAIT_STATES, 0: extra cycles inserted before the first ack or err of every cycle or burst (0..15).
- BURST_EN, 1: when 0, every request is handled as classic regardless of cti.

Ports:
- clk  in  1  bus clock
- rst_n  in  1  asynchronous active-low reset
- cyc  in  1  bus cycle valid
- stb  in  1  strobe
- we  in  1  1=write, 0=read
- adr  in  32  byte address
- sel  in  4  byte enables for writes
- dat_ms  in  32  write data
- cti  in  3  cycle type: 000 classic, 010 incrementing, 111 end of burst
- bte  in  2  burst type; only 00 (linear) supports bursting
- dat_sm  out  32  read data
- ack  out  1  transfer acknowledge
- err  out  1  error acknowledge (address out of range)

Behaviour:
- Reset (rst_n low, asynchronous): ack=0, err=0, dat_sm=0, FSM=IDLE, wait counter=0. RAM contents are not cleared.
- Request condition: req = cyc & stb.
- Output qualification: ack = ack_q & req, err = err_q & req. Deasserting stb or cyc removes ack/err in the same cycle.
- Range check: word address >= MEM_WORDS gives err instead of ack, with the same timing. Such writes are discarded and dat_sm=0.
- FSM states: IDLE, WAIT, BEAT, GAP.
- IDLE, req seen at edge N:
  - Latch adr[31:2] into the internal pointer and issue the RAM read.
  - WAIT_STATES=0: go to BEAT; ack is visible in cycle N+1.
  - Otherwise: go to WAIT and load the counter with WAIT_STATES-1.
- WAIT: decrement the counter each cycle; at 0 go to BEAT. First ack appears WAIT_STATES+1 cycles after req.
- req dropped in WAIT: return to IDLE with no ack.
- BEAT (ack or err visible):
  - Read: dat_sm holds the RAM word at the pointer.
  - Write: in this cycle, bytes of dat_ms where sel[i]=1 are written at the pointer.
  - Burst continue condition: cti=010, bte=00, BURST_EN=1, req=1, and the beat was not an err.
  - If the continue condition holds: pointer <= pointer+1, the next word is prefetched, and the FSM stays in BEAT. One ack per cycle, no extra wait states within a burst.
  - If the continue condition does not hold: go to GAP. This covers cti=000, cti=111, any other bte, and BURST_EN=0.
  - Read-after-write to the same word inside a burst: write data is bypassed to dat_sm.
- Burst pointer wrap: when the pointer increments past MEM_WORDS-1, the next beat reports err. There is no wrap to 0.
- Master address mismatch during a burst: ignored; the internal pointer is authoritative.
- GAP: one cycle with ack=0 and err=0, then IDLE. Back-to-back classic cycles therefore complete one per 2+WAIT_STATES cycles.
- Abort: req falling in BEAT ends the burst and goes to GAP. A write beat without ack visible is not committed.
- Reset asserted mid-burst: outputs clear immediately and the FSM returns to IDLE on release.
- RAM: synchronous single-port, 1-cycle read latency, byte-write capable.

Test Plan:
- Classic read, WAIT_STATES=0: write 0xA5A5_0001 to adr 0x10, then read adr 0x10 → ack one cycle after req, dat_sm=0xA5A5_0001, ack low the next cycle.
- Byte-enable write: preload 0x1122_3344 at adr 0x20, write 0xFFFF_FFFF with sel=0101, read back → 0x11FF_33FF.
- Read burst of 8 from adr 0x40 (cti=010, last beat cti=111), RAM[i]=i:
  - 8 consecutive acks carrying 0x10..0x17.
  - Then one idle ack=0 cycle.
- WAIT_STATES=3, burst of 4 → first ack 4 cycles after req, then 3 more back-to-back acks; classic read takes 5 cycles from req to the next accepted req.
- Range errors, MEM_WORDS=1024:
  - Read at adr 0x1000 → err=1, ack=0, dat_sm=0.
  - Burst starting at word 1022 → ack, ack, then err on the third beat.
- Abort and reset: drop stb after the 2nd ack of a 8-beat write burst → only 2 words modified. Pulse rst_n low mid-burst → ack=0 immediately and next request served normally.
